// File: rtl/mvmul_pkg.sv
`default_nettype none
// ============================================================================
// mvmul_pkg : shared types and constants for the matrix-vector multiply engine
// Revision  : 1.0
// ============================================================================
package mvmul_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int FLUSH_DEPTH = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_WRITE  = 3'd3,
        S_FLUSH1 = 3'd4,
        S_FLUSH2 = 3'd5,
        S_DONE   = 3'd6
    } mvmul_state_t;

endpackage
`default_nettype wire

// File: rtl/mvmul_if.sv
`default_nettype none
// ============================================================================
// mvmul_if : RAM-side bus of the engine (two read ports, one write port)
// Revision : 1.0
// ============================================================================
interface mvmul_if
    import mvmul_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] raddr_0;
    logic [DATA_W-1:0] rdata_0;
    logic [ADDR_W-1:0] raddr_1;
    logic [DATA_W-1:0] rdata_1;
    logic [ADDR_W-1:0] waddr_0;
    logic [DATA_W-1:0] wdata_0;
    logic              wen_0;

    modport master (
        output raddr_0, raddr_1, waddr_0, wdata_0, wen_0,
        input  rdata_0, rdata_1
    );

    modport slave (
        input  raddr_0, raddr_1, waddr_0, wdata_0, wen_0,
        output rdata_0, rdata_1
    );
endinterface
`default_nettype wire

// File: rtl/mvmul_mac.sv
`default_nettype none
// ============================================================================
// mvmul_mac : registered multiply-accumulate, products and sum wrap mod 2^DATA_W
// Revision  : 1.0
// ============================================================================
module mvmul_mac
    import mvmul_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear,
    input  wire logic              en,
    input  wire logic [DATA_W-1:0] a,
    input  wire logic [DATA_W-1:0] b,
    output logic      [DATA_W-1:0] acc
);
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_prod;

    assign w_prod = a * b;
    assign acc    = r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + w_prod;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mvmul_engine.sv
`default_nettype none
// ============================================================================
// mvmul_engine : y = A*x over a shared RAM; A, x read, y written back
// Revision     : 1.0
// ============================================================================
module mvmul_engine
    import mvmul_pkg::*;
#(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int A_BASE = 0,
    parameter int X_BASE = 9,
    parameter int Y_BASE = 12
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic start,
    mvmul_if.master   bus,
    output logic      busy,
    output logic      valid
);
    localparam int R_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int C_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [R_W-1:0] ROW_LAST = R_W'(ROWS - 1);
    localparam logic [C_W-1:0] COL_LAST = C_W'(COLS - 1);

    mvmul_state_t      r_state, w_state_nxt;
    logic [R_W-1:0]    r_row, w_row_nxt;
    logic [C_W-1:0]    r_col, w_col_nxt;
    logic              r_valid;
    logic              w_clear, w_acc_en;
    logic [DATA_W-1:0] w_acc;
    logic [ADDR_W-1:0] w_a_idx, w_x_idx, w_y_idx;

    assign w_a_idx = ADDR_W'(A_BASE) + ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);
    assign w_x_idx = ADDR_W'(X_BASE) + ADDR_W'(r_col);
    assign w_y_idx = ADDR_W'(Y_BASE) + ADDR_W'(r_row);
    assign valid   = r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            // Rises one edge after DONE is reached; an accepted start clears it.
            r_valid <= (r_state == S_DONE) && !start;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_clear     = 1'b0;
        w_acc_en    = 1'b0;
        busy        = 1'b1;
        bus.raddr_0 = '0;
        bus.raddr_1 = '0;
        bus.waddr_0 = '0;
        bus.wdata_0 = '0;
        bus.wen_0   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            S_RUN: begin
                bus.raddr_0 = w_a_idx;
                bus.raddr_1 = w_x_idx;
                // Column 0 has no read in flight yet, so it restarts the sum.
                w_clear     = (r_col == '0);
                w_acc_en    = (r_col != '0);
                if (r_col == COL_LAST) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_col_nxt = r_col + 1'b1;
                end
            end
            S_DRAIN: begin
                w_acc_en    = 1'b1;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                bus.wen_0   = 1'b1;
                bus.waddr_0 = w_y_idx;
                bus.wdata_0 = w_acc;
                if (r_row == ROW_LAST) begin
                    w_state_nxt = S_FLUSH1;
                end else begin
                    w_row_nxt   = r_row + 1'b1;
                    w_col_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_FLUSH1: w_state_nxt = S_FLUSH2;
            S_FLUSH2: w_state_nxt = S_DONE;
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    mvmul_mac #(
        .DATA_W (DATA_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .en    (w_acc_en),
        .a     (bus.rdata_0),
        .b     (bus.rdata_1),
        .acc   (w_acc)
    );
endmodule
`default_nettype wire
